// File: rtl/draw_duck.sv
// ---------------------------------------------------------------------------
// draw_duck -- overlays a rectangular sprite (fetched from an external
// synchronous ROM) onto an upstream VGA pixel stream.
//
// The pipeline has three register stages. Every *_out signal lags its *_in
// counterpart by exactly three clk cycles.
//   stage 1 : rectangle hit test and ROM address generation
//   stage 2 : alignment with the ROM read latency (rom_rgb arrives here)
//   stage 3 : colour-key compositing into rgb_out
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   duck_x, duck_y            requested sprite top-left corner (pixels)
//   duck_visible              request to draw the sprite
//   facing_left               horizontal mirror request (mirror build only)
//   hcount_in .. vblnk_in     upstream VGA timing
//   rgb_in                    upstream background pixel
//   rom_address               registered sprite ROM address, y*DUCK_W + x
//   rom_rgb                   sprite ROM data, valid one clk after rom_address
//   hcount_out .. rgb_out     delayed, composited VGA stream
//
// Build option
//   DRAW_DUCK_MIRROR_EN       adds facing_left; when it is latched high the
//                             sprite columns are read right-to-left.
// ---------------------------------------------------------------------------
module draw_duck #(
   parameter int          DUCK_W          = 96,
   parameter int          DUCK_H          = 60,
   parameter logic [11:0] TRANSPARENT_RGB = 12'hF0F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] duck_x,
   input  logic [10:0] duck_y,
   input  logic        duck_visible,
`ifdef DRAW_DUCK_MIRROR_EN
   input  logic        facing_left,
`endif
   input  logic [10:0] hcount_in,
   input  logic [10:0] vcount_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        hblnk_in,
   input  logic        vblnk_in,
   input  logic [11:0] rgb_in,
   output logic [12:0] rom_address,
   input  logic [11:0] rom_rgb,
   output logic [10:0] hcount_out,
   output logic [10:0] vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        hblnk_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   localparam logic [11:0] W12 = 12'(DUCK_W);
   localparam logic [11:0] H12 = 12'(DUCK_H);
   localparam logic [12:0] W13 = 13'(DUCK_W);

   // Timing bundle carried through the pipeline: {hcount, vcount, hsync,
   // vsync, hblnk, vblnk, rgb}. The blank bits sit at [13] and [12].
   localparam int TW = 38;

   // Frame registers: sprite placement is frozen for a whole frame.
   logic [10:0] x_reg;
   logic [10:0] y_reg;
   logic        vis_reg;
`ifdef DRAW_DUCK_MIRROR_EN
   logic        face_reg;
`endif

   logic [TW-1:0] tim_in;
   logic [TW-1:0] tim_s1_reg;
   logic [TW-1:0] tim_s2_reg;
   logic          in_rect_s1_reg;
   logic          in_rect_s2_reg;

   // Hit test and address arithmetic are done at 12 bits so x+DUCK_W
   // cannot wrap back onto the left edge of the screen.
   logic [11:0] h12, v12, x12, y12;
   logic [11:0] dx, dy, col;
   logic        in_rect_next;
   logic [12:0] addr_next;

   assign tim_in = {hcount_in, vcount_in, hsync_in, vsync_in,
                    hblnk_in, vblnk_in, rgb_in};

   assign h12 = {1'b0, hcount_in};
   assign v12 = {1'b0, vcount_in};
   assign x12 = {1'b0, x_reg};
   assign y12 = {1'b0, y_reg};
   assign dx  = h12 - x12;
   assign dy  = v12 - y12;

   assign in_rect_next = vis_reg
                         && (h12 >= x12) && (h12 <= x12 + W12 - 12'd1)
                         && (v12 >= y12) && (v12 <= y12 + H12 - 12'd1);

`ifdef DRAW_DUCK_MIRROR_EN
   assign col = face_reg ? (W12 - 12'd1 - dx) : dx;
`else
   assign col = dx;
`endif

   // Only meaningful when in_rect_next is set; dx < DUCK_W and dy < DUCK_H
   // then bound the address to DUCK_W*DUCK_H-1.
   assign addr_next = 13'(dy) * W13 + 13'(col);

   always_ff @(posedge clk) begin
      if (rst) begin
         x_reg          <= '0;
         y_reg          <= '0;
         vis_reg        <= 1'b0;
`ifdef DRAW_DUCK_MIRROR_EN
         face_reg       <= 1'b0;
`endif
         in_rect_s1_reg <= 1'b0;
         in_rect_s2_reg <= 1'b0;
         tim_s1_reg     <= '0;
         tim_s2_reg     <= '0;
         rom_address    <= '0;
         hcount_out     <= '0;
         vcount_out     <= '0;
         hsync_out      <= 1'b0;
         vsync_out      <= 1'b0;
         hblnk_out      <= 1'b0;
         vblnk_out      <= 1'b0;
         rgb_out        <= '0;
      end else begin
         // Latch placement at the first pixel of the frame; the hit test on
         // that same pixel still uses the previous frame's placement.
         if (hcount_in == 11'd0 && vcount_in == 11'd0) begin
            x_reg    <= duck_x;
            y_reg    <= duck_y;
            vis_reg  <= duck_visible;
`ifdef DRAW_DUCK_MIRROR_EN
            face_reg <= facing_left;
`endif
         end

         // Stage 1
         in_rect_s1_reg <= in_rect_next;
         tim_s1_reg     <= tim_in;
         if (in_rect_next)
            rom_address <= addr_next;

         // Stage 2: rom_rgb for this pixel becomes valid during this stage
         in_rect_s2_reg <= in_rect_s1_reg;
         tim_s2_reg     <= tim_s1_reg;

         // Stage 3
         hcount_out <= tim_s2_reg[37:27];
         vcount_out <= tim_s2_reg[26:16];
         hsync_out  <= tim_s2_reg[15];
         vsync_out  <= tim_s2_reg[14];
         hblnk_out  <= tim_s2_reg[13];
         vblnk_out  <= tim_s2_reg[12];
         if (in_rect_s2_reg && (rom_rgb != TRANSPARENT_RGB)
             && !tim_s2_reg[13] && !tim_s2_reg[12])
            rgb_out <= rom_rgb;
         else
            rgb_out <= tim_s2_reg[11:0];
      end
   end

endmodule

// File: tb/tb_draw_duck.sv
// ---------------------------------------------------------------------------
// tb_draw_duck -- directed test of draw_duck. Each driven pixel pushes its
// expected output onto a scoreboard queue; a negedge checker pops and
// compares once the three-cycle pipeline has produced the matching output.
// The bench acts as the synchronous sprite ROM (data = rom_f(address)).
// ---------------------------------------------------------------------------
module tb_draw_duck;

   localparam int          W  = 96;
   localparam int          H  = 60;
   localparam logic [11:0] TR = 12'hF0F;

   typedef struct {
      logic [25:0] tim;   // {hcount, vcount, hsync, vsync, hblnk, vblnk}
      logic [11:0] rgb;
      logic [12:0] addr;
      bit          chk_addr;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [10:0] duck_x = '0, duck_y = '0;
   logic        duck_visible = 1'b0;
`ifdef DRAW_DUCK_MIRROR_EN
   logic        facing_left = 1'b0;
`endif
   logic [10:0] hcount_in = '0, vcount_in = '0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0;
   logic [12:0] rom_address;
   logic [11:0] rom_rgb = '0;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   draw_duck dut (
      .clk(clk), .rst(rst),
      .duck_x(duck_x), .duck_y(duck_y), .duck_visible(duck_visible),
`ifdef DRAW_DUCK_MIRROR_EN
      .facing_left(facing_left),
`endif
      .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in),
      .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .rom_address(rom_address), .rom_rgb(rom_rgb),
      .hcount_out(hcount_out), .vcount_out(vcount_out),
      .hsync_out(hsync_out), .vsync_out(vsync_out),
      .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   // Sprite content: address 980 (pixel 120,60 at origin 100,50) and every
   // address with a%7==3 are transparent; address 3557 yields 12'h840.
   function automatic logic [11:0] rom_f(input int a);
      if (a == 980 || (a % 7) == 3) return TR;
      return 12'(a) ^ 12'h5A5;
   endfunction

   always @(posedge clk) rom_rgb <= rom_f(int'(rom_address));

   // rom_address for a pixel is visible one cycle after it is driven; delay
   // it two more so it lines up with the pixel's rgb_out.
   logic [12:0] addr_d1 = '0, addr_d2 = '0;
   always @(posedge clk) begin
      addr_d1 <= rom_address;
      addr_d2 <= addr_d1;
   end

   exp_t sb[$];
   exp_t ec;
   int   checks = 0;
   int   errors = 0;

   always @(negedge clk) begin
      if (sb.size() > 3) begin
         ec = sb.pop_front();
         checks++;
         assert (rgb_out === ec.rgb) else begin
            errors++;
            $error("FAIL rgb_out got %h expected %h (hcount_out=%0d vcount_out=%0d)",
                   rgb_out, ec.rgb, hcount_out, vcount_out);
         end
         checks++;
         assert ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} === ec.tim) else begin
            errors++;
            $error("FAIL timing got %h expected %h",
                   {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, ec.tim);
         end
         if (ec.chk_addr) begin
            checks++;
            assert (addr_d2 === ec.addr) else begin
               errors++;
               $error("FAIL rom_address got %0d expected %0d (hcount_out=%0d vcount_out=%0d)",
                      addr_d2, ec.addr, hcount_out, vcount_out);
            end
         end
      end
   end

   // Requested placement (applied to the DUT inputs with each pixel).
   int cfg_x = 0, cfg_y = 0;
   bit cfg_vis = 0, cfg_face = 0;
   // Model of the latched frame placement and the held ROM address.
   int mx = 0, my = 0, maddr = 0;
   bit mv = 0, mf = 0;

   task automatic px(input int h, input int v, input bit r = 0,
                     input bit hb = 0, input bit vb = 0);
      exp_t        e;
      exp_t        z;
      logic [11:0] bg;
      logic [11:0] rv;
      bit          hs, vs, inr;
      int          dxm, lo;
      @(posedge clk); #1;
      bg = 12'((h * 7 + v * 13) & 32'hFFF);
      hs = ((h / 16) % 2) == 1;
      vs = ((v / 2) % 2) == 1;
      rst = r;
      hcount_in = 11'(h); vcount_in = 11'(v);
      hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
      rgb_in = bg;
      duck_x = 11'(cfg_x); duck_y = 11'(cfg_y); duck_visible = cfg_vis;
`ifdef DRAW_DUCK_MIRROR_EN
      facing_left = cfg_face;
`endif
      if (r) begin
         // Reset wipes the two pixels still inside the pipeline.
         lo = (sb.size() > 2) ? sb.size() - 2 : 0;
         for (int i = lo; i < sb.size(); i++) begin
            z = sb[i];
            z.tim = '0; z.rgb = '0; z.chk_addr = 0;
            sb[i] = z;
         end
         e.tim = '0; e.rgb = '0; e.addr = '0; e.chk_addr = 1;
         mx = 0; my = 0; mv = 0; mf = 0; maddr = 0;
      end else begin
         inr = mv && h >= mx && h <= mx + W - 1 && v >= my && v <= my + H - 1;
         if (inr) begin
            dxm = mf ? (W - 1 - (h - mx)) : (h - mx);
            maddr = (v - my) * W + dxm;
         end
         rv = rom_f(maddr);
         e.tim = {11'(h), 11'(v), hs, vs, hb, vb};
         e.rgb = (inr && rv != TR && !hb && !vb) ? rv : bg;
         e.addr = 13'(maddr);
         e.chk_addr = 1;
         if (h == 0 && v == 0) begin
            mx = cfg_x; my = cfg_y; mv = cfg_vis;
`ifdef DRAW_DUCK_MIRROR_EN
            mf = cfg_face;
`endif
         end
      end
      sb.push_back(e);
   endtask

   initial begin
      // Reset state, then a frame with the old (reset) placement: nothing drawn.
      for (int i = 0; i < 5; i++) px(i + 3, 7, 1);
      cfg_x = 100; cfg_y = 50; cfg_vis = 1;
      px(120, 60);
      // Frame start latches 100,50; corners and just-outside neighbours.
      px(0, 0);
      px(100, 50); px(101, 50); px(195, 109); px(99, 50); px(196, 109);
      px(100, 49); px(100, 110); px(195, 50); px(100, 109);
      px(120, 60);                // transparent sprite pixel
      px(105, 87);                // sprite pixel 12'h840
      px(110, 55, 0, 1, 0);       // horizontal blank inside sprite
      px(111, 55, 0, 0, 1);       // vertical blank inside sprite
      for (int i = 0; i < 40; i++)
         px($urandom_range(90, 205), $urandom_range(45, 115));
      // Mid-frame move: stays at 100 until the next frame start.
      cfg_x = 300;
      px(0, 200); px(100, 60); px(300, 60); px(150, 70);
      px(0, 0);
      px(300, 60); px(100, 60); px(395, 60); px(396, 60);
      // Right screen edge on a 1024-wide line: columns 0..23 only.
      cfg_x = 1000;
      px(0, 0);
      for (int h = 995; h < 1024; h++) px(h, 52);
      px(0, 52); px(5, 52);
      // Reset pulse mid-sprite: background only until the next frame start.
      cfg_x = 100;
      px(0, 0);
      px(110, 55); px(111, 55); px(112, 55, 1);
      for (int h = 113; h < 120; h++) px(h, 55);
      px(0, 0);
      px(110, 55); px(111, 55);
      // Invisible frame: background everywhere.
      cfg_vis = 0;
      px(0, 0);
      px(100, 50); px(150, 80); px(195, 109);
`ifdef DRAW_DUCK_MIRROR_EN
      cfg_vis = 1; cfg_face = 1;
      px(0, 0);
      px(100, 50); px(195, 50); px(150, 70);
`endif
      // Drain the pipeline.
      for (int i = 0; i < 4; i++) px(500, 500);
      @(negedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
